// File: rtl/aes_pkg.sv
// Shared AES definitions: state/byte types, GF(2^8) helpers and the InvMixColumns column.
// The forward cipher reuses everything here except the FSM encoding.
package aes_pkg;
   localparam int NR = 10;

   typedef logic [7:0]   byte_t;
   typedef logic [127:0] state_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ROUND = 2'd1,
      S_FINAL = 2'd2
   } fsm_t;

   function automatic byte_t xtime(input byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic byte_t gmul(input byte_t a, input byte_t b);
      byte_t acc;
      byte_t p;
      acc = '0;
      p   = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Column bytes are row 0 at the LSB, matching the state byte layout.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      byte_t a0, a1, a2, a3, b0, b1, b2, b3;
      a0 = c[7:0];
      a1 = c[15:8];
      a2 = c[23:16];
      a3 = c[31:24];
      b0 = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
      b1 = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
      b2 = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
      b3 = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      return {b3, b2, b1, b0};
   endfunction
endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// Block handshake and round-key fetch bus of the iterative inverse cipher.
interface aes_inv_cipher_iter_if;
   import aes_pkg::*;

   logic       start;
   state_t     ciphertext;
   logic [3:0] rk_idx;
   state_t     rk;
   logic       busy;
   logic       done;
   state_t     plaintext;

   modport master (output start, ciphertext, rk, input rk_idx, busy, done, plaintext);
   modport slave  (input start, ciphertext, rk, output rk_idx, busy, done, plaintext);
endinterface

// File: rtl/aes_inv_sbox.sv
// Combinational AES inverse S-box, one byte in, one byte out.
module aes_inv_sbox
   import aes_pkg::*;
(
   input  byte_t i_byte,
   output byte_t o_byte
);
   localparam byte_t LUT [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };

   assign o_byte = LUT[i_byte];
endmodule

// File: rtl/inverse_shift_Rows.sv
// InvShiftRows: row r rotates right by r columns; pure wiring.
module inverse_shift_Rows
   import aes_pkg::*;
(
   input  state_t i_state,
   output state_t o_state
);
   for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar r = 0; r < 4; r++) begin : g_row
         assign o_state[8*(r+4*c) +: 8] = i_state[8*(r+4*((c+4-r)%4)) +: 8];
      end
   end
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, 11 cycles start-to-done,
// round keys fetched combinationally by index from the external key store.
module aes_inv_cipher_iter
   import aes_pkg::*;
(
   input  logic                  i_clk,
   input  logic                  i_rst,
   aes_inv_cipher_iter_if.slave  bus
);
   fsm_t       r_fsm, w_fsm_nxt;
   logic [3:0] r_round;
   state_t     r_state;
   state_t     r_pt;
   logic       r_done;

   state_t     w_isr, w_isb, w_ark, w_imc;
   logic [3:0] w_rk_idx;

   inverse_shift_Rows u_isr (.i_state(r_state), .o_state(w_isr));

   for (genvar b = 0; b < 16; b++) begin : g_sbox
      aes_inv_sbox u_sbox (.i_byte(w_isr[8*b +: 8]), .o_byte(w_isb[8*b +: 8]));
   end

   // The shared XOR serves both the middle rounds and the final round (rk_idx=0).
   assign w_ark = w_isb ^ bus.rk;

   for (genvar c = 0; c < 4; c++) begin : g_imc
      assign w_imc[32*c +: 32] = inv_mix_col(w_ark[32*c +: 32]);
   end

   always_comb begin
      w_fsm_nxt = r_fsm;
      unique case (r_fsm)
         S_IDLE:  if (bus.start) w_fsm_nxt = S_ROUND;
         S_ROUND: if (r_round == 4'd1) w_fsm_nxt = S_FINAL;
         S_FINAL: w_fsm_nxt = S_IDLE;
         default: w_fsm_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) r_fsm <= S_IDLE;
      else       r_fsm <= w_fsm_nxt;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= '0;
         r_round <= '0;
         r_pt    <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= (r_fsm == S_FINAL);
         unique case (r_fsm)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= bus.ciphertext ^ bus.rk;
                  r_round <= 4'(NR - 1);
               end
            end
            S_ROUND: begin
               r_state <= w_imc;
               r_round <= r_round - 4'd1;
            end
            S_FINAL: r_pt <= w_ark;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_rk_idx = 4'(NR);
      unique case (r_fsm)
         S_ROUND: w_rk_idx = r_round;
         S_FINAL: w_rk_idx = 4'd0;
         default: w_rk_idx = 4'(NR);
      endcase
   end

   assign bus.rk_idx    = w_rk_idx;
   assign bus.busy      = (r_fsm != S_IDLE);
   assign bus.done      = r_done;
   assign bus.plaintext = r_pt;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: known vectors, protocol corners, random blocks
// against a forward-cipher model built from GF(2^8) arithmetic.
module tb_aes_inv_cipher_iter;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_inv_cipher_iter_if bus ();
   aes_inv_cipher_iter dut (.i_clk(clk), .i_rst(rst), .bus(bus));

   logic [7:0] sb_in, sb_out;
   aes_inv_sbox u_sb (.i_byte(sb_in), .o_byte(sb_out));

   logic [127:0] rkeys [16];
   logic [7:0]   fwd   [256];
   int           rk_seq [12];
   int           n_tests = 0;
   int           n_fail  = 0;

   assign bus.rk = rkeys[bus.rk_idx];

   localparam logic [127:0] C1_KEY = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] C1_CT  = 128'h5ac5b47080b7cdd830047b6ad8e0c469;
   localparam logic [127:0] C1_PT  = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] Z_CT   = 128'h2e2b34ca59fa4c883b2c8aefd44be966;

   typedef struct { logic [7:0] din; logic [7:0] dexp; } sb_vec_t;
   typedef struct { logic [127:0] key; logic [127:0] ct; logic [127:0] pt; string nm; } blk_vec_t;

   // Carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [15:0] prod;
      prod = '0;
      for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (prod[i]) prod = prod ^ (16'h011b << (i - 8));
      return prod[7:0];
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         fwd[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic key_expand(input logic [127:0] key);
      logic [7:0] w [44][4];
      logic [7:0] tmp [4];
      logic [7:0] tt, rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) w[i][j] = key[8*(4*i+j) +: 8];
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
         if (i % 4 == 0) begin
            tt = tmp[0];
            tmp[0] = fwd[tmp[1]] ^ rc;
            tmp[1] = fwd[tmp[2]];
            tmp[2] = fwd[tmp[3]];
            tmp[3] = fwd[tt];
            rc = gm(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
      end
      for (int r = 0; r < 11; r++)
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) rkeys[r][8*(4*c+j) +: 8] = w[4*r+c][j];
      for (int r = 11; r < 16; r++) rkeys[r] = '0;
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ rkeys[0][8*i +: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) t[i] = fwd[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r+4*c] = t[r+4*((c+r)%4)];
         if (rd < 10)
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
               s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
            end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rkeys[rd][8*i +: 8];
      end
      for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
      return res;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Starts a block in the current cycle; optional extra start pulses / reset at edge N+k.
   task automatic run_block(input logic [127:0] ct, input int pulse_a, input int pulse_b,
                            input int rst_at, output logic [127:0] pt, output int lat,
                            output logic [127:0] mid_pt);
      rk_seq[0] = int'(bus.rk_idx);
      bus.start = 1'b1;
      bus.ciphertext = ct;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
      lat = 0;
      mid_pt = bus.plaintext;
      while (!bus.done && lat < 30) begin
         if (lat < 11) rk_seq[lat+1] = int'(bus.rk_idx);
         bus.start = (lat + 1 == pulse_a) || (lat + 1 == pulse_b);
         rst = (rst_at != 0) && (lat + 1 == rst_at);
         @(posedge clk); #1;
         bus.start = 1'b0;
         bus.ciphertext = {$urandom, $urandom, $urandom, $urandom};
         lat++;
         if (lat == 5) mid_pt = bus.plaintext;
         if (rst) begin
            rst = 1'b0;
            break;
         end
      end
      pt = bus.plaintext;
   endtask

   initial begin
      sb_vec_t  sbv [4];
      blk_vec_t bv  [2];
      logic [127:0] pt, pt2, mid, rpt, rkey, rct;
      int lat, lat2;
      logic saw_done;

      rst = 1'b1;
      bus.start = 1'b0;
      bus.ciphertext = '0;
      for (int r = 0; r < 16; r++) rkeys[r] = '0;
      sb_in = 8'h00;

      build_sbox();

      sbv[0] = '{8'h63, 8'h00};
      sbv[1] = '{8'h00, 8'h52};
      sbv[2] = '{8'h16, 8'hff};
      sbv[3] = '{8'h7c, 8'h01};
      for (int i = 0; i < 4; i++) begin
         sb_in = sbv[i].din; #1;
         check($sformatf("sbox_unit_%0d", i), 128'(sb_out), 128'(sbv[i].dexp));
      end
      for (int x = 0; x < 256; x++) begin
         sb_in = fwd[x]; #1;
         check($sformatf("sbox_roundtrip_%0d", x), 128'(sb_out), 128'(x));
      end

      key_expand(C1_KEY);
      check("model_c1", encrypt(C1_PT), C1_CT);

      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_done", 128'(bus.done), 128'd0);
      check("rst_pt", bus.plaintext, 128'd0);
      check("rst_rkidx", 128'(bus.rk_idx), 128'd10);
      rst = 1'b0;
      @(posedge clk); #1;

      bv[0] = '{C1_KEY, C1_CT, C1_PT, "c1"};
      bv[1] = '{128'd0, Z_CT, 128'd0, "zero"};
      for (int v = 0; v < 2; v++) begin
         key_expand(bv[v].key);
         run_block(bv[v].ct, 0, 0, 0, pt, lat, mid);
         check({bv[v].nm, "_pt"}, pt, bv[v].pt);
         check({bv[v].nm, "_latency"}, 128'(lat), 128'd10);
         for (int k = 0; k <= 10; k++)
            check($sformatf("%s_rkidx_%0d", bv[v].nm, k), 128'(rk_seq[k]), 128'(10 - k));
         @(posedge clk); #1;
         check({bv[v].nm, "_done_width"}, 128'(bus.done), 128'd0);
         check({bv[v].nm, "_busy_after"}, 128'(bus.busy), 128'd0);
         check({bv[v].nm, "_pt_held"}, bus.plaintext, bv[v].pt);
      end

      key_expand(C1_KEY);
      run_block(C1_CT, 3, 7, 0, pt, lat, mid);
      check("ignored_start_pt", pt, C1_PT);
      check("ignored_start_latency", 128'(lat), 128'd10);

      rpt = {$urandom, $urandom, $urandom, $urandom};
      rct = encrypt(rpt);
      run_block(C1_CT, 0, 0, 0, pt, lat, mid);
      run_block(rct, 0, 0, 0, pt2, lat2, mid);
      check("b2b_first_pt", pt, C1_PT);
      check("b2b_total_latency", 128'(lat + 1 + lat2), 128'd21);
      check("b2b_pt_held_midway", mid, C1_PT);
      check("b2b_second_pt", pt2, rpt);

      run_block(C1_CT, 0, 0, 5, pt, lat, mid);
      check("midrst_busy", 128'(bus.busy), 128'd0);
      check("midrst_done", 128'(bus.done), 128'd0);
      check("midrst_pt", bus.plaintext, 128'd0);
      check("midrst_rkidx", 128'(bus.rk_idx), 128'd10);
      saw_done = 1'b0;
      repeat (15) begin
         @(posedge clk); #1;
         if (bus.done) saw_done = 1'b1;
      end
      check("midrst_no_done", 128'(saw_done), 128'd0);
      run_block(C1_CT, 0, 0, 0, pt, lat, mid);
      check("after_rst_pt", pt, C1_PT);
      @(posedge clk); #1;

      bus.start = 1'b1;
      bus.ciphertext = Z_CT;
      rst = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      rst = 1'b0;
      check("rst_beats_start_busy", 128'(bus.busy), 128'd0);
      saw_done = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus.done) saw_done = 1'b1;
      end
      check("rst_beats_start_no_done", 128'(saw_done), 128'd0);

      for (int n = 0; n < 12; n++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom};
         rpt  = {$urandom, $urandom, $urandom, $urandom};
         key_expand(rkey);
         rct = encrypt(rpt);
         run_block(rct, 0, 0, 0, pt, lat, mid);
         check($sformatf("rand_%0d_pt", n), pt, rpt);
         check($sformatf("rand_%0d_latency", n), 128'(lat), 128'd10);
         if (n % 3 == 0) begin
            @(posedge clk); #1;
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
